// File: rtl/dac_update_scheduler.sv
// Round-robin sharing of a dual-channel SPI DAC driver, with frame pacing and a done timeout.
// Optional macro DAC_SCHED_OVERRUN_EN adds overrun_cnt, which counts frame slots dropped while busy.
module dac_update_scheduler #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 12,
  parameter int TICK_DIV     = 25000,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic                      CLK_50M,
  input  logic                      RST_N,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_chan,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         dac_Va,
  output logic [DATA_W-1:0]         dac_Vb,
  output logic                      dac_start,
  input  logic                      dac_done,
  output logic                      busy,
  output logic                      err_timeout
`ifdef DAC_SCHED_OVERRUN_EN
  ,
  output logic [7:0]                overrun_cnt
`endif
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int TCK_W = $clog2(TICK_DIV);
  localparam int WT_W  = $clog2(DONE_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_START = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [1:0]        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  cand;
  logic              gnt_any;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_chan;
  logic [DATA_W-1:0] shadow_a;
  logic [DATA_W-1:0] shadow_b;
  logic              dirty;
  logic [TCK_W-1:0]  tick_cnt;
  logic              tick;
  logic [WT_W-1:0]   wait_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Arbiter: first valid requester at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign gnt_chan  = req_chan[gnt_idx];
  assign tick      = (tick_cnt == TCK_W'(TICK_DIV - 1));
  assign dac_start = (state == ST_START);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr   <= '0;
      shadow_a <= '0;
      shadow_b <= '0;
      dirty    <= 1'b0;
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (gnt_any) begin
        if (gnt_chan) shadow_b <= gnt_data;
        else          shadow_a <= gnt_data;
        rr_ptr <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      // A grant landing in LOAD keeps dirty so that write goes out next slot
      if (gnt_any)                dirty <= 1'b1;
      else if (state == ST_LOAD)  dirty <= 1'b0;
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      dac_Va      <= '0;
      dac_Vb      <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (tick && dirty) state <= ST_LOAD;
        ST_LOAD: begin
          dac_Va <= shadow_a;
          dac_Vb <= shadow_b;
          state  <= ST_START;
        end
        ST_START: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        default: begin
          if (dac_done) begin
            state <= ST_IDLE;
          end else if (wait_cnt == WT_W'(DONE_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef DAC_SCHED_OVERRUN_EN
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N)                       overrun_cnt <= 8'd0;
    else if (tick && state != ST_IDLE) overrun_cnt <= sat_inc8(overrun_cnt);
  end
`endif

endmodule
